// File: rtl/ovc_grant_sched_pkg.sv
// Shared types and helpers for the output-VC grant scheduler: FSM encoding and
// the class-to-VC mask lookup used wherever a requester's candidate VCs are needed.
package ovc_grant_sched_pkg;

   localparam int MAX_V  = 32;
   localparam int MAX_CS = 256;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   typedef enum logic [0:0] {
      IDLE  = ST_IDLE,
      GRANT = ST_GRANT
   } state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // With one (or no) class every VC is allowed; an unknown class gets no VCs.
   function automatic logic [MAX_V-1:0] class_mask(
      input logic [MAX_CS-1:0] setting,
      input int unsigned       v,
      input int unsigned       c,
      input int unsigned       cls
   );
      logic [MAX_V-1:0] m;
      m = '0;
      if (c <= 1) begin
         for (int unsigned b = 0; b < MAX_V; b++) begin
            if (b < v) m[b] = 1'b1;
         end
      end else if (cls < c) begin
         for (int unsigned b = 0; b < MAX_V; b++) begin
            if (b < v) m[b] = setting[cls*v + b];
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/ovc_grant_sched_if.sv
// Request/grant/release bundle between the input VCs (master) and the
// output-VC scheduler (slave).
interface ovc_grant_sched_if
   import ovc_grant_sched_pkg::*;
#(
   parameter int V   = 4,
   parameter int NR  = 4,
   parameter int Cw  = 1,
   parameter int IDW = idx_w(NR)
);
   logic [NR-1:0]    req;
   logic [NR*Cw-1:0] req_class;
   logic             release_valid;
   logic [V-1:0]     release_ovc;
   logic             grant_valid;
   logic [IDW-1:0]   grant_id;
   logic [V-1:0]     grant_ovc;
   logic [V-1:0]     ovc_free;
   logic             release_err;

   modport master (
      output req, req_class, release_valid, release_ovc,
      input  grant_valid, grant_id, grant_ovc, ovc_free, release_err
   );

   modport slave (
      input  req, req_class, release_valid, release_ovc,
      output grant_valid, grant_id, grant_ovc, ovc_free, release_err
   );
endinterface

// File: rtl/ovc_grant_sched_rr_arbiter_ptr.sv
// Round-robin arbiter: first asserted request at or after ptr, wrapping
// through N-1 back to 0; one-hot grant, all-zero when nothing requests.
module rr_arbiter_ptr #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt
);
   int   idx;
   logic found;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end
endmodule

// File: rtl/ovc_grant_sched.sv
// Output-VC allocator for one router port: round-robin over class-eligible
// requesters, one grant per two cycles, free-pool tracking with checked releases.
module ovc_grant_sched
   import ovc_grant_sched_pkg::*;
#(
   parameter int V  = 4,
   parameter int C  = 2,
   parameter int Cw = (C > 1) ? $clog2(C) : 1,
   parameter logic [C*V-1:0] CLASS_SETTING = {4'b1100, 4'b0011},
   parameter int NR = 4
) (
   input  logic clk,
   input  logic reset,
   ovc_grant_sched_if.slave bus
);
   localparam int IDW = idx_w(NR);

   state_e           state_q, state_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]   grant_id_q, grant_id_d;
   logic [V-1:0]     grant_ovc_q, grant_ovc_d;
   logic [V-1:0]     ovc_free_q, ovc_free_d;
   logic             release_err_q, release_err_d;

   logic [V-1:0]     allowed [NR];
   logic [NR-1:0]    eligible;
   logic [NR-1:0]    arb_gnt;
   logic [MAX_V-1:0] mask_full;
   logic [IDW-1:0]   win_id;
   logic [V-1:0]     win_avail;
   logic [V-1:0]     win_ovc;
   logic [V-1:0]     alloc_ovc;
   logic             rel_ok;

   always_comb begin : class_masks
      mask_full = '0;
      for (int i = 0; i < NR; i++) begin
         mask_full   = class_mask(MAX_CS'(CLASS_SETTING), V, C, 32'(bus.req_class[i*Cw +: Cw]));
         allowed[i]  = mask_full[V-1:0];
         eligible[i] = bus.req[i] && ((allowed[i] & ovc_free_q) != '0);
      end
   end

   rr_arbiter_ptr #(.N(NR), .PW(IDW)) u_arb (
      .req (eligible),
      .ptr (rr_ptr_q),
      .gnt (arb_gnt)
   );

   // Descending scan so the last hit, i.e. the lowest free allowed VC, wins.
   always_comb begin : winner
      win_id = '0;
      for (int i = 0; i < NR; i++) begin
         if (arb_gnt[i]) win_id = IDW'(i);
      end
      win_avail = allowed[win_id] & ovc_free_q;
      win_ovc   = '0;
      for (int v = V - 1; v >= 0; v--) begin
         if (win_avail[v]) begin
            win_ovc    = '0;
            win_ovc[v] = 1'b1;
         end
      end
   end

   always_comb begin : next_state
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_id_d  = grant_id_q;
      grant_ovc_d = grant_ovc_q;
      alloc_ovc   = '0;
      case (state_q)
         IDLE: begin
            if (|eligible) begin
               state_d     = GRANT;
               grant_id_d  = win_id;
               grant_ovc_d = win_ovc;
               alloc_ovc   = win_ovc;
               rr_ptr_d    = (int'(win_id) == NR - 1) ? '0 : win_id + IDW'(1);
            end
         end
         default: begin
            state_d     = IDLE;
            grant_id_d  = '0;
            grant_ovc_d = '0;
         end
      endcase

      // Allocation only takes VCs free in ovc_free_q and a legal release only
      // targets busy ones, so the two never touch the same bit.
      rel_ok        = bus.release_valid && $onehot(bus.release_ovc)
                      && ((bus.release_ovc & ~ovc_free_q) != '0);
      release_err_d = bus.release_valid && !rel_ok;
      ovc_free_d    = (ovc_free_q & ~alloc_ovc) | (rel_ok ? bus.release_ovc : '0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         rr_ptr_q      <= '0;
         grant_id_q    <= '0;
         grant_ovc_q   <= '0;
         ovc_free_q    <= '1;
         release_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         grant_id_q    <= grant_id_d;
         grant_ovc_q   <= grant_ovc_d;
         ovc_free_q    <= ovc_free_d;
         release_err_q <= release_err_d;
      end
   end

   assign bus.grant_valid = (state_q == GRANT);
   assign bus.grant_id    = grant_id_q;
   assign bus.grant_ovc   = grant_ovc_q;
   assign bus.ovc_free    = ovc_free_q;
   assign bus.release_err = release_err_q;

endmodule

// File: tb/tb_ovc_grant_sched.sv
// Bench for ovc_grant_sched: directed scenarios with literal expectations, then
// randomized requests/releases checked every cycle against a behavioural model.
module tb_ovc_grant_sched;
   localparam int V   = 4;
   localparam int C   = 2;
   localparam int Cw  = 1;
   localparam int NR  = 4;
   localparam int IDW = 2;
   localparam logic [C*V-1:0] CLASS_SETTING = {4'b1100, 4'b0011};

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   ovc_grant_sched_if #(.V(V), .NR(NR), .Cw(Cw), .IDW(IDW)) bus ();

   ovc_grant_sched #(
      .V(V), .C(C), .Cw(Cw), .CLASS_SETTING(CLASS_SETTING), .NR(NR)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: free pool, round-robin start, whether last edge issued a grant.
   logic [V-1:0] m_free;
   int           m_rr;
   bit           m_in_grant;
   bit           e_gv;
   int           e_gid;
   logic [V-1:0] e_govc;
   bit           e_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit allowed(int cls, int v);
      logic [C*V-1:0] cs;
      cs = CLASS_SETTING;
      if (C <= 1) return 1'b1;
      if (cls >= C) return 1'b0;
      return cs[cls*V + v];
   endfunction

   function automatic void model_reset();
      m_free     = '1;
      m_rr       = 0;
      m_in_grant = 1'b0;
      e_gv       = 1'b0;
      e_gid      = 0;
      e_govc     = '0;
      e_err      = 1'b0;
   endfunction

   // What the next clock edge must produce given the inputs currently driven.
   function automatic void model_step();
      int           win, pick, cls, cnt;
      logic [V-1:0] nf;
      win  = -1;
      pick = -1;
      if (!m_in_grant) begin
         for (int k = 0; k < NR && win < 0; k++) begin
            int i;
            i   = (m_rr + k) % NR;
            cls = int'(bus.req_class[i*Cw +: Cw]);
            if (bus.req[i]) begin
               for (int v = 0; v < V && win < 0; v++) begin
                  if (allowed(cls, v) && m_free[v]) begin
                     win  = i;
                     pick = v;
                  end
               end
            end
         end
      end
      nf    = m_free;
      e_err = 1'b0;
      if (win >= 0) nf[pick] = 1'b0;
      if (bus.release_valid) begin
         cnt = $countones(bus.release_ovc);
         if (cnt == 1 && (bus.release_ovc & ~m_free) != '0) nf = nf | bus.release_ovc;
         else e_err = 1'b1;
      end
      e_gv   = (win >= 0);
      e_gid  = (win >= 0) ? win : 0;
      e_govc = (win >= 0) ? (V'(1) << pick) : '0;
      if (win >= 0) m_rr = (win + 1) % NR;
      m_in_grant = (win >= 0);
      m_free     = nf;
   endfunction

   task automatic step();
      model_step();
      @(posedge clk);
      @(negedge clk);
      chk("grant_valid", 32'(bus.grant_valid), 32'(e_gv));
      chk("grant_id",    32'(bus.grant_id),    32'(e_gid));
      chk("grant_ovc",   32'(bus.grant_ovc),   32'(e_govc));
      chk("ovc_free",    32'(bus.ovc_free),    32'(m_free));
      chk("release_err", 32'(bus.release_err), 32'(e_err));
   endtask

   task automatic clear_inputs();
      bus.req           = '0;
      bus.req_class     = '0;
      bus.release_valid = 1'b0;
      bus.release_ovc   = '0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      clear_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_grant_valid", 32'(bus.grant_valid), 32'd0);
      chk("rst_grant_id",    32'(bus.grant_id),    32'd0);
      chk("rst_grant_ovc",   32'(bus.grant_ovc),   32'd0);
      chk("rst_ovc_free",    32'(bus.ovc_free),    32'hF);
      chk("rst_release_err", 32'(bus.release_err), 32'd0);
      reset = 1'b1;
   endtask

   int rv;

   initial begin
      clear_inputs();
      do_reset();

      // Single class-0 request
      bus.req = 4'b0001;
      step();
      chk("t1_gv",   32'(bus.grant_valid), 32'd1);
      chk("t1_id",   32'(bus.grant_id),    32'd0);
      chk("t1_ovc",  32'(bus.grant_ovc),   32'h1);
      chk("t1_free", 32'(bus.ovc_free),    32'hE);
      bus.req = '0;
      step();
      chk("t1_gv_off", 32'(bus.grant_valid), 32'd0);

      // Four class-1 requesters contend for VCs 2 and 3
      do_reset();
      bus.req       = 4'b1111;
      bus.req_class = 4'b1111;
      step();
      chk("t2_id0",  32'(bus.grant_id),  32'd0);
      chk("t2_ovc0", 32'(bus.grant_ovc), 32'h4);
      bus.req[0] = 1'b0;
      step();
      step();
      chk("t2_id1",  32'(bus.grant_id),  32'd1);
      chk("t2_ovc1", 32'(bus.grant_ovc), 32'h8);
      bus.req[1] = 1'b0;
      step();
      step();
      chk("t2_blocked", 32'(bus.grant_valid), 32'd0);
      bus.release_valid = 1'b1;
      bus.release_ovc   = 4'b0100;
      step();
      chk("t2_rel_free", 32'(bus.ovc_free), 32'h7);
      bus.release_valid = 1'b0;
      bus.release_ovc   = '0;
      step();
      chk("t2_id2",  32'(bus.grant_id),  32'd2);
      chk("t2_ovc2", 32'(bus.grant_ovc), 32'h4);
      bus.req = '0;
      step();

      // Class-0 pool exhausted must not block a class-1 requester
      do_reset();
      bus.req = 4'b0011;
      step();
      bus.req[0] = 1'b0;
      step();
      step();
      chk("t3_ovc_b", 32'(bus.grant_ovc), 32'h2);
      bus.req[1] = 1'b0;
      step();
      bus.req       = 4'b0011;
      bus.req_class = 4'b0010;
      step();
      chk("t3_id",  32'(bus.grant_id),  32'd1);
      chk("t3_ovc", 32'(bus.grant_ovc), 32'h4);
      bus.req[1] = 1'b0;
      step();
      step();
      chk("t3_req0_pending", 32'(bus.grant_valid), 32'd0);
      bus.req = '0;
      step();

      // Illegal releases
      do_reset();
      bus.release_valid = 1'b1;
      bus.release_ovc   = 4'b0001;
      step();
      chk("t4_err_free", 32'(bus.release_err), 32'd1);
      chk("t4_free",     32'(bus.ovc_free),    32'hF);
      bus.release_ovc = 4'b0011;
      step();
      chk("t4_err_multi", 32'(bus.release_err), 32'd1);
      bus.release_valid = 1'b0;
      bus.release_ovc   = '0;
      step();
      chk("t4_err_clear", 32'(bus.release_err), 32'd0);

      // Release of VC 2 on the same edge as an allocation
      do_reset();
      bus.req       = 4'b0001;
      bus.req_class = 4'b0001;
      step();
      chk("t5_take2", 32'(bus.grant_ovc), 32'h4);
      bus.req = '0;
      step();
      bus.req           = 4'b0010;
      bus.req_class     = 4'b0010;
      bus.release_valid = 1'b1;
      bus.release_ovc   = 4'b0100;
      step();
      chk("t5_ovc",  32'(bus.grant_ovc), 32'h8);
      chk("t5_free", 32'(bus.ovc_free),  32'h7);
      bus.req           = '0;
      bus.release_valid = 1'b0;
      bus.release_ovc   = '0;
      step();

      // Asynchronous reset while a grant is showing
      do_reset();
      bus.req = 4'b0001;
      step();
      chk("t6_pre_gv", 32'(bus.grant_valid), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("t6_gv",   32'(bus.grant_valid), 32'd0);
      chk("t6_id",   32'(bus.grant_id),    32'd0);
      chk("t6_ovc",  32'(bus.grant_ovc),   32'd0);
      chk("t6_free", 32'(bus.ovc_free),    32'hF);
      chk("t6_err",  32'(bus.release_err), 32'd0);
      clear_inputs();
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      step();
      chk("t6_no_grant", 32'(bus.grant_valid), 32'd0);

      // Randomized traffic
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < NR; i++) begin
            if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
               bus.req[i]              = 1'b1;
               bus.req_class[i*Cw +: Cw] = Cw'($urandom_range(0, C - 1));
            end
         end
         bus.release_valid = 1'b0;
         bus.release_ovc   = '0;
         if ($urandom_range(0, 2) == 0) begin
            if ($urandom_range(0, 7) == 0) begin
               bus.release_valid = 1'b1;
               bus.release_ovc   = V'($urandom_range(0, (1 << V) - 1));
            end else begin
               rv = int'($urandom_range(0, V - 1));
               if (!m_free[rv]) begin
                  bus.release_valid = 1'b1;
                  bus.release_ovc   = V'(1) << rv;
               end
            end
         end
         step();
         if (e_gv) bus.req[e_gid] = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
